vip_src_sched: RTL
==================

# vip_src_sched

Frame-synchronous source scheduler for the camera-to-Ethernet video path, clocked by the camera pixel clock. It arbitrates between up to five processed pixel streams (raw, filtered, Sobel, binarised, rotated), using a debounced remote-control command code to pick one. A selection change takes effect only at a frame boundary. The chosen 16-bit RGB565 stream is serialised into a gap-tolerant byte stream for the UDP image packetiser.

## Interface
Parameters:
- N_SRC, 5: number of source streams (2..8).
- DEF_SEL, 0: source index selected out of reset.
- STABLE_CYC, 4: consecutive identical synchronised samples required to accept a command (1..15).

Ports:
- cam_pclk  in  1  pixel clock; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- remote_data  in  8  IR command code; asynchronous to cam_pclk; level-held.
- src_vsync  in  N_SRC  per-source frame sync, high during vertical blanking.
- src_href  in  N_SRC  per-source line valid.
- src_de  in  N_SRC  per-source pixel strobe, one cycle per 16-bit pixel.
- src_data  in  16*N_SRC  per-source pixel; source k occupies bits [16k+15:16k].
- img_vsync  out  1  selected vsync, registered.
- img_href  out  1  selected href, registered.
- img_data_en  out  1  img_data valid this cycle.
- img_data  out  8  output byte; high byte first, then low byte.
- cur_sel  out  3  active source index.
- sel_pending  out  1  an accepted command is waiting for a frame boundary.
- ovf_err  out  1  sticky pixel-buffer overflow; clears at the next frame boundary.

## Operation
- Command path:
  - remote_data passes through a 2-flop synchroniser.
  - A code is accepted when the synchronised value is unchanged for STABLE_CYC cycles. It is not re-accepted until the value changes again.
  - Code map: 8'h16→0, 8'h19→1, 8'h0D→2, 8'h0C→3, 8'h18→4.
  - Unmapped codes, and indices ≥ N_SRC, are ignored; the current selection and pending state are unchanged.
  - An accepted index equal to cur_sel with nothing pending is ignored.
- FSM, states RUN and ARMED:
  - RUN: an accepted index is stored in next_sel; sel_pending=1; go to ARMED.
  - ARMED: a further accepted index overwrites next_sel, last one wins. Accepting an index equal to cur_sel cancels the switch: sel_pending=0, return to RUN.
  - Frame boundary = rising edge of src_vsync[cur_sel], detected against a registered copy.
  - At a boundary in ARMED: cur_sel←next_sel; sel_pending=0; pixel buffer flushed; ovf_err cleared; return to RUN.
  - At a boundary in RUN: ovf_err cleared; nothing else changes.
  - The edge detector is re-seeded from the new source's vsync in the switch cycle, so a switch can never cause a spurious second boundary.
- Pixel buffer:
  - 2-entry 16-bit FIFO with a byte-phase flag.
  - Writes on src_de[cur_sel].
  - Drains one byte per cycle: high byte, then low byte; the entry is popped after its low byte.
  - A write with the FIFO full and no pop that cycle is dropped and sets ovf_err.
  - A simultaneous write and pop on a full FIFO is legal.
- Sideband: img_vsync and img_href are src_vsync[cur_sel] and src_href[cur_sel], each delayed one cycle.

## Timing
- Reset values:
  - cur_sel=DEF_SEL, next_sel=DEF_SEL, FSM=RUN.
  - img_vsync, img_href, img_data_en, sel_pending and ovf_err = 0; img_data=8'h00.
  - FIFO empty, byte phase = high, synchroniser and stability counter cleared.
- Byte latency: a pixel strobed at cycle t with the FIFO empty gives its high byte at t+1 and its low byte at t+2, with img_data_en=1 in both cycles.
- Throughput: sustained de every 2 cycles (the OV5640 capture rate) never overflows. Back-to-back de is absorbed for at most 2 pixels.
- Command latency: the 2 synchroniser cycles plus STABLE_CYC cycles before sel_pending rises.
- Switch cycle:
  - The boundary edge is detected in cycle b; cur_sel changes at the end of b.
  - A de from the old source in cycle b is discarded. From b+1 only the new source's de is written.
  - A byte due in b+1 from the old FIFO content is not emitted.
- Bytes still draining may extend up to 3 cycles past the falling edge of img_href; the packetiser counts on img_data_en only.
- Reset asserted mid-frame returns every register to its reset value immediately. Output resumes from the next de of DEF_SEL; no boundary is needed.

## Test plan
- Reset, then source 0 strobes de every 2 cycles with data 16'hA55A, 16'h1234 → bytes A5,5A,12,34 on consecutive cycles, first byte 1 cycle after the first de; cur_sel=0.
- remote_data=8'h19 held, STABLE_CYC=4 → sel_pending=1 exactly 6 cycles later. Next src_vsync[0] rising edge → cur_sel=1, sel_pending=0. Source 1 pixel 16'hBEEF then appears as BE,EF.
- remote_data glitches 8'h0C for 3 cycles, then returns to 8'h16 → no acceptance, sel_pending stays 0. Unmapped 8'h45 held → ignored.
- In ARMED, 8'h0D is accepted and then 8'h0C before the boundary → switch lands on 3. Alternatively 8'h0D then the current code → sel_pending drops, no switch.
- Three back-to-back de on source 0 with the FIFO empty → 2 pixels (4 bytes) emitted, third dropped, ovf_err=1. ovf_err clears on the next vsync rising edge.
- Assert rst_n low mid-line while ARMED with bytes queued → all outputs 0 the same instant, cur_sel=DEF_SEL; no stale bytes after release.

Source files
------------

// File: rtl/vip_src_sched.sv
// Frame-synchronous source scheduler: picks one of N_SRC pixel streams by debounced
// remote command, switches only on the active source's vsync rise, and serialises RGB565 to bytes.

package vip_src_sched_pkg;
  typedef struct packed {
    logic        vsync;
    logic        href;
    logic        de;
    logic [15:0] data;
  } src_beat_t;
endpackage

// One source lane: passes its stream through only while it is the active source,
// so the top can merge all lanes with a plain OR.
module vip_src_sched_lane
  import vip_src_sched_pkg::*;
#(
  parameter int LANE_ID = 0
) (
  input  logic [2:0]  cur_sel,
  input  logic        vsync,
  input  logic        href,
  input  logic        de,
  input  logic [15:0] data,
  output src_beat_t   beat
);
  logic hit;

  assign hit        = (cur_sel == 3'(LANE_ID));
  assign beat.vsync = hit & vsync;
  assign beat.href  = hit & href;
  assign beat.de    = hit & de;
  assign beat.data  = hit ? data : 16'h0000;
endmodule

module vip_src_sched
  import vip_src_sched_pkg::*;
#(
  parameter int N_SRC      = 5,
  parameter int DEF_SEL    = 0,
  parameter int STABLE_CYC = 4
) (
  input  logic                  cam_pclk,
  input  logic                  rst_n,
  input  logic [7:0]            remote_data,
  input  logic [N_SRC-1:0]      src_vsync,
  input  logic [N_SRC-1:0]      src_href,
  input  logic [N_SRC-1:0]      src_de,
  input  logic [16*N_SRC-1:0]   src_data,
  output logic                  img_vsync,
  output logic                  img_href,
  output logic                  img_data_en,
  output logic [7:0]            img_data,
  output logic [2:0]            cur_sel,
  output logic                  sel_pending,
  output logic                  ovf_err
);

  typedef enum logic {RUN, ARMED} state_t;

  // {valid, index}
  function automatic logic [3:0] code_map(input logic [7:0] code);
    case (code)
      8'h16:   code_map = 4'b1000;
      8'h19:   code_map = 4'b1001;
      8'h0D:   code_map = 4'b1010;
      8'h0C:   code_map = 4'b1011;
      8'h18:   code_map = 4'b1100;
      default: code_map = 4'b0000;
    endcase
  endfunction

  // ---------------- source lanes ----------------
  logic [N_SRC-1:0][15:0] data_arr;
  src_beat_t [N_SRC-1:0]  beats;
  src_beat_t              sel_beat;

  assign data_arr = src_data;

  for (genvar k = 0; k < N_SRC; k++) begin : g_lane
    vip_src_sched_lane #(.LANE_ID(k)) u_lane (
      .cur_sel (cur_sel),
      .vsync   (src_vsync[k]),
      .href    (src_href[k]),
      .de      (src_de[k]),
      .data    (data_arr[k]),
      .beat    (beats[k])
    );
  end

  always_comb begin
    sel_beat = '0;
    for (int k = 0; k < N_SRC; k++) sel_beat = src_beat_t'(sel_beat | beats[k]);
  end

  // ---------------- command path ----------------
  logic [7:0] sync1, sync2, last_code;
  logic [3:0] stab_cnt, stab_run, cmd_map;
  logic [2:0] cmd_idx;
  logic       cmd_acc, cmd_ok;

  // Run length saturates at STABLE_CYC so a held code fires exactly once.
  always_comb begin
    stab_run = 4'd1;
    if (sync2 == last_code)
      stab_run = (stab_cnt == 4'(STABLE_CYC)) ? stab_cnt : stab_cnt + 4'd1;
    cmd_acc = (stab_run == 4'(STABLE_CYC)) &&
              ((sync2 != last_code) || (stab_cnt != 4'(STABLE_CYC)));
    cmd_map = code_map(sync2);
    cmd_idx = cmd_map[2:0];
    cmd_ok  = cmd_acc && cmd_map[3] && ({1'b0, cmd_idx} < 4'(N_SRC));
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 8'h00;
      sync2     <= 8'h00;
      last_code <= 8'h00;
      stab_cnt  <= 4'd0;
    end else begin
      sync1     <= remote_data;
      sync2     <= sync1;
      last_code <= sync2;
      stab_cnt  <= stab_run;
    end
  end

  // ---------------- selection FSM ----------------
  state_t     state, state_d;
  logic [2:0] next_sel, next_sel_d, cur_d;
  logic       vs_q, vs_seed, boundary, sw;

  assign boundary = sel_beat.vsync & ~vs_q;

  always_comb begin
    state_d    = state;
    next_sel_d = next_sel;
    cur_d      = cur_sel;
    sw         = 1'b0;
    if (boundary && state == ARMED) begin
      cur_d   = next_sel;
      sw      = 1'b1;
      state_d = RUN;
    end
    if (cmd_ok) begin
      if (state_d == RUN) begin
        if (cmd_idx != cur_d) begin
          next_sel_d = cmd_idx;
          state_d    = ARMED;
        end
      end else if (cmd_idx == cur_d) begin
        state_d = RUN;
      end else begin
        next_sel_d = cmd_idx;
      end
    end
  end

  // Edge detector follows whichever source is active next cycle, so a switch re-seeds it.
  always_comb begin
    vs_seed = 1'b0;
    for (int k = 0; k < N_SRC; k++)
      if (cur_d == 3'(k)) vs_seed = src_vsync[k];
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cur_sel  <= 3'(DEF_SEL);
      next_sel <= 3'(DEF_SEL);
      vs_q     <= 1'b0;
    end else begin
      state    <= state_d;
      cur_sel  <= cur_d;
      next_sel <= next_sel_d;
      vs_q     <= vs_seed;
    end
  end

  assign sel_pending = (state == ARMED);

  // ---------------- pixel buffer / serialiser ----------------
  // A slot stays occupied until the cycle after its low byte has been on img_data,
  // which bounds back-to-back bursts at two pixels.
  logic [15:0] mem [2];
  logic        wptr, iptr, phase, show_lo, pop_q;
  logic [1:0]  occ, pend;
  logic        wr, wr_ok, drop, iss, iss_lo;
  logic [15:0] head;
  logic [7:0]  obyte;

  always_comb begin
    wr     = sel_beat.de & ~sw;
    wr_ok  = wr & ((occ != 2'd2) | pop_q);
    drop   = wr & (occ == 2'd2) & ~pop_q;
    head   = (pend != 2'd0) ? mem[iptr] : sel_beat.data;
    iss    = (pend != 2'd0) | wr_ok;
    iss_lo = iss & phase;
    obyte  = phase ? head[7:0] : head[15:8];
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]      <= 16'h0000;
      mem[1]      <= 16'h0000;
      wptr        <= 1'b0;
      iptr        <= 1'b0;
      phase       <= 1'b0;
      occ         <= 2'd0;
      pend        <= 2'd0;
      show_lo     <= 1'b0;
      pop_q       <= 1'b0;
      img_data_en <= 1'b0;
      img_data    <= 8'h00;
    end else if (sw) begin
      wptr        <= 1'b0;
      iptr        <= 1'b0;
      phase       <= 1'b0;
      occ         <= 2'd0;
      pend        <= 2'd0;
      show_lo     <= 1'b0;
      pop_q       <= 1'b0;
      img_data_en <= 1'b0;
      img_data    <= 8'h00;
    end else begin
      if (wr_ok) begin
        mem[wptr] <= sel_beat.data;
        wptr      <= ~wptr;
      end
      if (iss)    phase <= ~phase;
      if (iss_lo) iptr  <= ~iptr;
      pend        <= pend + 2'(wr_ok) - 2'(iss_lo);
      occ         <= occ + 2'(wr_ok) - 2'(pop_q);
      show_lo     <= iss_lo;
      pop_q       <= show_lo;
      img_data_en <= iss;
      img_data    <= iss ? obyte : 8'h00;
    end
  end

  // ---------------- sideband / error ----------------
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      img_vsync <= 1'b0;
      img_href  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      img_vsync <= sel_beat.vsync;
      img_href  <= sel_beat.href;
      if (drop)          ovf_err <= 1'b1;
      else if (boundary) ovf_err <= 1'b0;
    end
  end

endmodule
